// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3, 4-state Viterbi decoder.
//   NUM_STATES  : trellis state count
//   state_t     : 2-bit trellis state, s[1] = most recent input bit
//   predecessor : survivor predecessor of state s given its decision vector
//   tb_state_e  : traceback FSM states
package viterbi_pkg;

    localparam int NUM_STATES = 4;

    typedef logic [1:0] state_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        TRACE = 2'd1,
        EMIT  = 2'd2
    } tb_state_e;

    // Predecessor of s is {s[0], dec[s]}: shifting back one step drops the
    // newest input bit and recovers the older bit from the ACS decision.
    function automatic state_t predecessor(input state_t s,
                                           input logic [NUM_STATES-1:0] d);
        return {s[0], d[s]};
    endfunction

endpackage

// File: rtl/tb_dec_mem.sv
// Survivor-decision buffer: L x 4 register file.
//   clk         : clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata : asynchronous read port
// Contents are not reset; a frame always overwrites every entry before it
// is read back.
module tb_dec_mem #(
    parameter int L  = 8,
    parameter int AW = $clog2(L)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [3:0]    rdata
);

    logic [3:0] mem [L];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/viterbi_traceback.sv
// Traceback stage of the K=3, 4-state Viterbi decoder.
// Buffers L survivor-decision vectors, traces the survivor path back from a
// start state (0 when TERM, else the best_state seen with the last decision)
// and emits the decoded bits in chronological order.
//   clk, rst                        : clock, synchronous active-high reset
//   dec_valid/dec_ready/dec         : decision-vector input handshake
//   best_state                      : min-metric state, used on last step only
//   out_valid/out_ready/out_bit/out_last : decoded-bit output handshake
//   busy                            : high while tracing or emitting
module viterbi_traceback
    import viterbi_pkg::*;
#(
    parameter int L    = 8,
    parameter bit TERM = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dec_valid,
    output logic       dec_ready,
    input  logic [3:0] dec,
    input  logic [1:0] best_state,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit,
    output logic       out_last,
    output logic       busy
);

    localparam int            AW   = $clog2(L);
    localparam logic [AW-1:0] LAST = AW'(L - 1);

    tb_state_e     state_q, state_d;
    logic [AW-1:0] wptr, rptr, optr;
    state_t        s;
    logic [L-1:0]  obuf;
    logic [3:0]    rd_dec;
    logic          wr_en;

    // Writes only happen in FILL, so decisions offered while busy are dropped.
    assign wr_en = dec_valid && (state_q == FILL);

    tb_dec_mem #(.L(L), .AW(AW)) u_dmem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr),
        .wdata (dec),
        .raddr (rptr),
        .rdata (rd_dec)
    );

    // Next-state and handshake outputs. out_valid is purely a state decode,
    // so it never depends on out_ready.
    always_comb begin
        state_d   = state_q;
        dec_ready = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (state_q)
            FILL: begin
                dec_ready = 1'b1;
                if (wr_en && (wptr == LAST)) state_d = TRACE;
            end
            TRACE: begin
                busy = 1'b1;
                if (rptr == '0) state_d = EMIT;
            end
            EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_bit   = obuf[optr];
                out_last  = (optr == LAST);
                if (out_ready && (optr == LAST)) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            wptr    <= '0;
            rptr    <= '0;
            optr    <= '0;
            s       <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                FILL: begin
                    if (wr_en) begin
                        if (wptr == LAST) begin
                            wptr <= '0;
                            rptr <= LAST;
                            s    <= TERM ? state_t'(0) : state_t'(best_state);
                        end else begin
                            wptr <= wptr + 1'b1;
                        end
                    end
                end
                TRACE: begin
                    s <= predecessor(s, rd_dec);
                    if (rptr == '0) optr <= '0;
                    else            rptr <= rptr - 1'b1;
                end
                EMIT: begin
                    if (out_ready) begin
                        if (optr == LAST) optr <= '0;
                        else              optr <= optr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Traceback walks backwards in time, so each step's bit lands at its
    // chronological slot and EMIT can simply read upwards from 0.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == TRACE)) obuf[rptr] <= s[1];
    end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Self-checking bench: two instances (TERM=0 and TERM=1) share all inputs.
// Expected bits are queued when a frame is driven and popped on each output
// handshake.
module tb_viterbi_traceback;
    import viterbi_pkg::*;

    localparam int L = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid, out_ready;
    logic [3:0] dec;
    logic [1:0] best_state;
    logic       dec_ready0, out_valid0, out_bit0, out_last0, busy0;
    logic       dec_ready1, out_valid1, out_bit1, out_last1, busy1;

    always #5 clk = ~clk;

    viterbi_traceback #(.L(L), .TERM(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready0),
        .dec(dec), .best_state(best_state), .out_valid(out_valid0),
        .out_ready(out_ready), .out_bit(out_bit0), .out_last(out_last0),
        .busy(busy0)
    );

    viterbi_traceback #(.L(L), .TERM(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready1),
        .dec(dec), .best_state(best_state), .out_valid(out_valid1),
        .out_ready(out_ready), .out_bit(out_bit1), .out_last(out_last1),
        .busy(busy1)
    );

    int checks = 0;
    int errors = 0;
    bit q0[$];
    bit q1[$];
    bit ql[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference traceback for the TERM=1 instance (start state 0).
    function automatic logic [L-1:0] ref_trace(input logic [L-1:0][3:0] d,
                                               input logic [1:0] st);
        logic [L-1:0] r;
        logic [1:0]   cur;
        cur = st;
        for (int k = L - 1; k >= 0; k--) begin
            r[k] = cur[1];
            cur  = {cur[0], d[k][cur]};
        end
        return r;
    endfunction

    // Encode input bits u from state 0 into a decision frame: the on-path
    // state gets its true predecessor bit, every other bit is random.
    task automatic mk_path(input logic [L-1:0] u, output logic [L-1:0][3:0] d,
                           output logic [1:0] fs);
        logic [1:0] cur, nxt;
        cur = 2'd0;
        for (int k = 0; k < L; k++) begin
            nxt       = {u[k], cur[1]};
            d[k]      = 4'($urandom);
            d[k][nxt] = cur[0];
            cur       = nxt;
        end
        fs = cur;
    endtask

    // Output monitor: scoreboard pops, stall stability, dec_ready while busy.
    bit   prev_stall = 1'b0;
    logic prev_bit, prev_last;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_vld", out_valid0, 1);
                chk("stall_bit", out_bit0, prev_bit);
                chk("stall_last", out_last0, prev_last);
            end
            if (busy0) begin
                chk("rdy_busy0", dec_ready0, 0);
                chk("busy1", busy1, 1);
            end
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) begin
                    chk("extra_out", 1, 0);
                end else begin
                    chk("vld1", out_valid1, 1);
                    chk("bit_t0", out_bit0, q0.pop_front());
                    chk("bit_t1", out_bit1, q1.pop_front());
                    chk("last0", out_last0, ql[0]);
                    chk("last1", out_last1, ql.pop_front());
                end
            end
            prev_stall = out_valid0 && !out_ready;
            prev_bit   = out_bit0;
            prev_last  = out_last0;
        end
    end

    // Drive one frame; returns #1 after the edge that accepts the last decision.
    task automatic send_frame(input logic [L-1:0][3:0] d, input logic [1:0] bs,
                              input logic [L-1:0] e0);
        logic [L-1:0] e1;
        int n;
        e1 = ref_trace(d, 2'd0);
        for (int k = 0; k < L; k++) begin
            q0.push_back(e0[k]);
            q1.push_back(e1[k]);
            ql.push_back(k == L - 1);
        end
        for (int k = 0; k < L; k++) begin
            dec        = d[k];
            best_state = (k == L - 1) ? bs : 2'($urandom);
            dec_valid  = 1'b1;
            n = 0;
            while (!dec_ready0 && n < 100) begin
                @(posedge clk); #1; n++;
            end
            if (n == 100) chk("fill_timeout", 0, 1);
            @(posedge clk); #1;
        end
        dec_valid = 1'b0;
    endtask

    // Latency to first out_valid, then drain the frame. When hold is set,
    // dec_valid stays high with junk until the block is back in FILL.
    task automatic drain(input bit bp, input bit hold);
        int n;
        if (hold) begin
            dec_valid = 1'b1;
            dec       = 4'($urandom);
        end
        n = 0;
        while (!out_valid0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", n, L);
        n = 0;
        while (busy0 && n < 200) begin
            out_ready = bp ? ~out_ready : 1'b1;
            if (hold) dec = 4'($urandom);
            @(posedge clk); #1; n++;
        end
        dec_valid = 1'b0;
        out_ready = 1'b1;
        if (!bp) chk("emit_cycles", n, L);
        chk("rdy_back", dec_ready0, 1);
        chk("q_empty", q0.size(), 0);
    endtask

    logic [L-1:0][3:0] d;
    logic [1:0]        fs;
    logic [L-1:0]      u;

    initial begin
        rst        = 1'b1;
        dec_valid  = 1'b0;
        out_ready  = 1'b1;
        dec        = '0;
        best_state = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy0", dec_ready0, 1);
        chk("rst_rdy1", dec_ready1, 1);
        chk("rst_vld", out_valid0, 0);
        chk("rst_bit", out_bit0, 0);
        chk("rst_last", out_last0, 0);
        chk("rst_busy", busy0, 0);
        rst = 1'b0;

        // All-zero frame; best_state=3 differentiates the two TERM settings.
        d = '0;
        send_frame(d, 2'd3, ref_trace(d, 2'd3));
        drain(1'b0, 1'b0);

        // All-zero, best_state 0: both instances decode all zeros.
        send_frame(d, 2'd0, '0);
        drain(1'b0, 1'b0);

        // All-ones with best_state 3.
        d = {L{4'b1111}};
        send_frame(d, 2'd3, '1);
        drain(1'b0, 1'b0);

        // Known path 1,0,1,1,0,0,1,0 (first bit in u[0]).
        u = 8'b0100_1101;
        mk_path(u, d, fs);
        chk("path_end", fs, 2'd1);
        send_frame(d, fs, u);
        drain(1'b0, 1'b0);

        // Same path under alternating backpressure.
        mk_path(u, d, fs);
        send_frame(d, fs, u);
        drain(1'b1, 1'b0);

        // dec_valid held high with junk through TRACE and EMIT.
        mk_path(u, d, fs);
        send_frame(d, fs, u);
        drain(1'b0, 1'b1);
        d = '0;
        send_frame(d, 2'd0, '0);
        drain(1'b0, 1'b0);

        // Random paths.
        for (int r = 0; r < 3; r++) begin
            u = L'($urandom);
            mk_path(u, d, fs);
            send_frame(d, fs, u);
            drain(r == 1, 1'b0);
        end

        // Reset in TRACE cycle 3 aborts the frame.
        mk_path(u, d, fs);
        send_frame(d, fs, u);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("trace_busy", busy0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_rdy", dec_ready0, 1);
        chk("abort_vld", out_valid0, 0);
        chk("abort_busy", busy0, 0);
        q0.delete();
        q1.delete();
        ql.delete();
        d = '0;
        send_frame(d, 2'd0, '0);
        drain(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
